// File: rtl/freelist.sv
// Physical-register free list: circular FIFO of tags, up to 4 allocations and 4 releases per cycle.
// Optional double-free / starvation detection is enabled by defining FREELIST_DBLFREE_CHK_EN.
module freelist #(
  parameter int WIDTH = 6,
  parameter int RSV   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [3:0]           i_req,
  input  logic                 i_en,
  input  logic [3:0]           i_freeVld,
  input  logic [4*WIDTH-1:0]   i_free4x,
  output logic [4*WIDTH-1:0]   o_addr4x,
  output logic                 o_ready,
  output logic [WIDTH:0]       o_count,
  output logic                 o_err
);

  localparam int SIZE = 1 << WIDTH;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] fifo_r [SIZE];
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic [WIDTH:0]   count_r;

  logic [WIDTH-1:0] rd_ptr_s;
  logic [WIDTH-1:0] wr_ptr_s;
  logic [2:0]       npop_s;
  logic [2:0]       npush_s;
  logic             pop_s;
  logic [3:0]       wr_en_s;
  logic [WIDTH-1:0] wr_idx_s [4];
  logic [WIDTH-1:0] free_tag_s [4];
  logic [WIDTH:0]   count_next_s;

  // Allocation: n-th requesting slot reads fifo[head+n]; rd_ptr_s ends at the new head.
  always_comb begin
    o_addr4x = '0;
    rd_ptr_s = head_r;
    npop_s   = 3'd0;
    for (int j = 0; j < 4; j++) begin
      if (i_req[j]) begin
        o_addr4x[j*WIDTH +: WIDTH] = fifo_r[rd_ptr_s];
        rd_ptr_s = rd_ptr_s + ONE;
        npop_s   = npop_s + 3'd1;
      end else begin
        o_addr4x[j*WIDTH +: WIDTH] = '0;
      end
    end
  end

  assign o_ready = (count_r >= (WIDTH+1)'(npop_s));
  assign pop_s   = i_en && o_ready;
  assign o_count = count_r;

  // Release: valid nonzero tags are compacted in slot order onto the tail.
  always_comb begin
    wr_ptr_s = tail_r;
    npush_s  = 3'd0;
    wr_en_s  = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      free_tag_s[j] = i_free4x[j*WIDTH +: WIDTH];
      wr_idx_s[j]   = wr_ptr_s;
      if (i_freeVld[j] && (free_tag_s[j] != '0)) begin
        wr_en_s[j] = 1'b1;
        wr_ptr_s   = wr_ptr_s + ONE;
        npush_s    = npush_s + 3'd1;
      end else begin
        wr_en_s[j] = 1'b0;
      end
    end
  end

  assign count_next_s = count_r + (WIDTH+1)'(npush_s)
                      - (pop_s ? (WIDTH+1)'(npop_s) : (WIDTH+1)'(0));

  // FIFO storage and pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SIZE; k++) begin
        fifo_r[k] <= (k < SIZE - RSV) ? WIDTH'(RSV + k) : '0;
      end
      head_r  <= '0;
      tail_r  <= WIDTH'(SIZE - RSV);
      count_r <= (WIDTH+1)'(SIZE - RSV);
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (wr_en_s[j]) begin
          fifo_r[wr_idx_s[j]] <= free_tag_s[j];
        end
      end
      tail_r  <= wr_ptr_s;
      head_r  <= pop_s ? rd_ptr_s : head_r;
      count_r <= count_next_s;
    end
  end

`ifdef FREELIST_DBLFREE_CHK_EN
  logic [SIZE-1:0] inlist_r;
  logic [7:0]      stall_r;
  logic            err_r;
  logic            dbl_s;
  logic            stall_s;

  // Duplicate-release detection against the registered membership vector and within the group.
  always_comb begin
    dbl_s = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (wr_en_s[j] && inlist_r[free_tag_s[j]]) begin
        dbl_s = 1'b1;
      end else begin
        dbl_s = dbl_s;
      end
      for (int k = 0; k < j; k++) begin
        if (wr_en_s[j] && wr_en_s[k] && (free_tag_s[j] == free_tag_s[k])) begin
          dbl_s = 1'b1;
        end else begin
          dbl_s = dbl_s;
        end
      end
    end
  end

  assign stall_s = i_en && !o_ready && (i_req != 4'b0000);
  assign o_err   = err_r;

  // Membership tracking, starvation counter and sticky error flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SIZE; k++) begin
        inlist_r[k] <= (k >= RSV);
      end
      stall_r <= 8'd0;
      err_r   <= 1'b0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (pop_s && i_req[j]) begin
          inlist_r[o_addr4x[j*WIDTH +: WIDTH]] <= 1'b0;
        end
      end
      for (int j = 0; j < 4; j++) begin
        if (wr_en_s[j]) begin
          inlist_r[free_tag_s[j]] <= 1'b1;
        end
      end
      if (stall_s) begin
        stall_r <= (stall_r == 8'd255) ? stall_r : stall_r + 8'd1;
        err_r   <= err_r | dbl_s | (stall_r == 8'd255);
      end else begin
        stall_r <= 8'd0;
        err_r   <= err_r | dbl_s;
      end
    end
  end
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_freelist.sv
// Self-checking bench for freelist: constant vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_freelist;
  localparam int WIDTH = 6;
  localparam int SIZE  = 64;
  localparam int RSV   = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [3:0]         req = 4'b0000;
  logic               en = 1'b0;
  logic [3:0]         fvld = 4'b0000;
  logic [4*WIDTH-1:0] free4x = '0;
  logic [4*WIDTH-1:0] addr4x;
  logic               ready;
  logic [WIDTH:0]     count;
  logic               err;

  freelist #(.WIDTH(WIDTH), .RSV(RSV)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_en(en), .i_freeVld(fvld),
    .i_free4x(free4x), .o_addr4x(addr4x), .o_ready(ready), .o_count(count), .o_err(err)
  );

  always #5 clk = ~clk;

  int q[$];
  int outs[$];
  int ftag[4];
  int exp_err;
  int stall_run;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic       en;
    int         a0, a1, a2, a3;
    int         rdy;
    int         cnt;
  } vec_t;
  vec_t tbl[9];

  function automatic int npop_of(logic [3:0] r);
    return int'(r[0]) + int'(r[1]) + int'(r[2]) + int'(r[3]);
  endfunction

  function automatic int in_q(int t);
    foreach (q[i]) if (q[i] == t) return 1;
    return 0;
  endfunction

  function automatic int slot(int j);
    return int'(addr4x[j*WIDTH +: WIDTH]);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < SIZE - RSV; k++) q.push_back(RSV + k);
    outs.delete();
    exp_err = 0;
    stall_run = 0;
  endtask

  task automatic drive(logic [3:0] r, logic e, logic [3:0] fv, int t0, int t1, int t2, int t3);
    req = r; en = e; fvld = fv;
    ftag[0] = t0; ftag[1] = t1; ftag[2] = t2; ftag[3] = t3;
    free4x = {WIDTH'(t3), WIDTH'(t2), WIDTH'(t1), WIDTH'(t0)};
  endtask

  task automatic check_model();
    int n;
    n = 0;
    chk("ready", int'(ready), (q.size() >= npop_of(req)) ? 1 : 0);
    chk("count", int'(count), q.size());
    chk("err", int'(err), exp_err);
    for (int j = 0; j < 4; j++) begin
      if (!req[j]) chk($sformatf("addr_idle%0d", j), slot(j), 0);
      else begin
        if (n < q.size()) chk($sformatf("addr%0d", j), slot(j), q[n]);
        n++;
      end
    end
  endtask

  task automatic advance();
    int np;
    bit rdy;
    @(posedge clk);
    #1;
    np = npop_of(req);
    rdy = (q.size() >= np);
`ifdef FREELIST_DBLFREE_CHK_EN
    for (int j = 0; j < 4; j++) begin
      if (fvld[j] && ftag[j] != 0) begin
        if (in_q(ftag[j]) != 0) exp_err = 1;
        for (int k = 0; k < j; k++)
          if (fvld[k] && ftag[k] == ftag[j]) exp_err = 1;
      end
    end
    if (en && !rdy && req != 4'b0000) begin
      stall_run++;
      if (stall_run > 255) exp_err = 1;
    end else stall_run = 0;
`endif
    if (en && rdy) repeat (np) outs.push_back(q.pop_front());
    for (int j = 0; j < 4; j++)
      if (fvld[j] && ftag[j] != 0) q.push_back(ftag[j]);
  endtask

  task automatic cyc(logic [3:0] r, logic e, logic [3:0] fv, int t0, int t1, int t2, int t3);
    drive(r, e, fv, t0, t1, t2, t3);
    @(negedge clk);
    check_model();
    advance();
  endtask

  task automatic take(int t);
    foreach (outs[i]) if (outs[i] == t) begin outs.delete(i); return; end
  endtask

  task automatic free_front(int n);
    int t[4];
    logic [3:0] fv;
    while (n > 0) begin
      fv = 4'b0000;
      for (int j = 0; j < 4; j++) begin
        t[j] = 0;
        if (n > 0) begin t[j] = outs.pop_front(); fv[j] = 1'b1; n--; end
      end
      cyc(4'b0000, 1'b0, fv, t[0], t[1], t[2], t[3]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_count", int'(count), SIZE - RSV);
    chk("rst_err", int'(err), 0);
    drive(4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int t[4];
    logic [3:0] fv;
    logic [3:0] r;
    logic e;
    int pick, idx;

    tbl[0] = '{1'b0, 4'b1111, 1'b1, 32, 33, 34, 35, 1, 32};
    tbl[1] = '{1'b0, 4'b1111, 1'b0, 36, 37, 38, 39, 1, 28};
    tbl[2] = '{1'b0, 4'b0101, 1'b1, 36,  0, 37,  0, 1, 28};
    tbl[3] = '{1'b0, 4'b0000, 1'b1,  0,  0,  0,  0, 1, 26};
    tbl[4] = '{1'b0, 4'b1000, 1'b1,  0,  0,  0, 38, 1, 26};
    tbl[5] = '{1'b0, 4'b0011, 1'b1, 39, 40,  0,  0, 1, 25};
    tbl[6] = '{1'b0, 4'b0000, 1'b0,  0,  0,  0,  0, 1, 23};
    tbl[7] = '{1'b1, 4'b0101, 1'b1, 32,  0, 33,  0, 1, 32};
    tbl[8] = '{1'b0, 4'b0000, 1'b0,  0,  0,  0,  0, 1, 30};

    #2;
    do_reset();

    // Constant vector table (basic allocation from reset)
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].req, tbl[i].en, 4'b0000, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("tbl%0d_a0", i), slot(0), tbl[i].a0);
      chk($sformatf("tbl%0d_a1", i), slot(1), tbl[i].a1);
      chk($sformatf("tbl%0d_a2", i), slot(2), tbl[i].a2);
      chk($sformatf("tbl%0d_a3", i), slot(3), tbl[i].a3);
      chk($sformatf("tbl%0d_ready", i), int'(ready), tbl[i].rdy);
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
      advance();
    end

    // Insufficient tags: stall holds state, then a release restores readiness
    do_reset();
    repeat (7) cyc(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0);
    cyc(4'b0011, 1'b1, 4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(4'b0111, 1'b1, 4'b0000, 0, 0, 0, 0);
      @(negedge clk);
      check_model();
      chk("stall_ready", int'(ready), 0);
      chk("stall_count", int'(count), 2);
      chk("stall_tag0", slot(0), 62);
      chk("stall_tag1", slot(1), 63);
      advance();
    end
    take(40); take(41);
    cyc(4'b0111, 1'b1, 4'b0011, 40, 41, 0, 0);
    drive(4'b0111, 1'b0, 4'b0000, 0, 0, 0, 0);
    @(negedge clk);
    chk("freed_ready", int'(ready), 1);
    chk("freed_count", int'(count), 4);
    advance();

    // Simultaneous pop 4 and push 3 plus a dropped tag-0 slot
    do_reset();
    cyc(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0);
    take(32); take(33); take(34);
    cyc(4'b1111, 1'b1, 4'b1111, 32, 33, 0, 34);
    drive(4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0);
    @(negedge clk);
    chk("pushpop_count", int'(count), 27);
    advance();
    repeat (6) cyc(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0);
    drive(4'b0111, 1'b1, 4'b0000, 0, 0, 0, 0);
    @(negedge clk);
    chk("order_s0", slot(0), 32);
    chk("order_s1", slot(1), 33);
    chk("order_s2", slot(2), 34);
    advance();

    // Wrap-around: release group straddles index 63 -> 0
    do_reset();
    repeat (8) cyc(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0);
    free_front(30);
    cyc(4'b0011, 1'b1, 4'b0000, 0, 0, 0, 0);
    free_front(4);
    repeat (7) cyc(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0);
    drive(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0);
    @(negedge clk);
    chk("wrap_s0", slot(0), 62);
    chk("wrap_s1", slot(1), 63);
    chk("wrap_s2", slot(2), 32);
    chk("wrap_s3", slot(3), 33);
    advance();

`ifdef FREELIST_DBLFREE_CHK_EN
    // Double free of a listed tag, then starvation
    do_reset();
    cyc(4'b0000, 1'b0, 4'b0001, 45, 0, 0, 0);
    drive(4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0);
    @(negedge clk);
    chk("dblfree_err", int'(err), 1);
    advance();
    repeat (3) cyc(4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0);
    do_reset();
    repeat (8) cyc(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0);
    repeat (258) cyc(4'b0001, 1'b1, 4'b0000, 0, 0, 0, 0);
    chk("starve_err", int'(err), 1);
`endif

    // Reset asserted in the middle of an allocation burst
    cyc(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0);
    drive(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0);
    #2;
    do_reset();

    // Randomized legal traffic against the queue model
    for (int c = 0; c < 400; c++) begin
      r = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 3) != 0);
      fv = 4'b0000;
      for (int j = 0; j < 4; j++) begin
        pick = $urandom_range(0, 3);
        t[j] = 0;
        if (pick < 2 && outs.size() > 0) begin
          idx = $urandom_range(0, outs.size() - 1);
          t[j] = outs[idx];
          outs.delete(idx);
          fv[j] = 1'b1;
        end else if (pick == 2) begin
          fv[j] = 1'b1;
        end else begin
          t[j] = $urandom_range(0, SIZE - 1);
        end
      end
      cyc(r, e, fv, t[0], t[1], t[2], t[3]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
